// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, coordinate type and default playfield geometry
// for the pong game sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_e;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_BALL_SIZE    = 25;
    localparam int DEF_PADDLE_W     = 10;
    localparam int DEF_PADDLE_H     = 150;
    localparam int DEF_PADDLE_L_X   = 40;
    localparam int DEF_PADDLE_R_X   = 600;
    localparam int DEF_BALL_SPEED   = 4;
    localparam int DEF_PADDLE_SPEED = 6;
    localparam int DEF_WIN_SCORE    = 9;
    localparam int DEF_SERVE_FRAMES = 60;

    // Ball and paddle rows share some line when the ball's span crosses the paddle's.
    function automatic logic overlap(input logic signed [10:0] ball_y, pad_y, ball_sz, pad_h);
        return (ball_y + ball_sz > pad_y) && (ball_y < pad_y + pad_h);
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// pong_paddle: one paddle's vertical position; moves by a fixed step per enabled
// frame and saturates at the top and bottom of the screen.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int V_RES        = DEF_V_RES,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED
) (
    input  logic   pixel_clk_i,
    input  logic   reset_n_i,
    input  logic   en_i,
    input  logic   up_i,
    input  logic   dn_i,
    output coord_t y_o
);
    localparam logic signed [10:0] MAX = 11'(V_RES - PADDLE_H);
    localparam logic signed [10:0] SPD = 11'(PADDLE_SPEED);
    localparam coord_t MID = coord_t'((V_RES - PADDLE_H) / 2);

    coord_t y_q, y_d;
    logic signed [10:0] y_up, y_dn;

    always_comb begin
        y_up = $signed({1'b0, y_q}) - SPD;
        y_dn = $signed({1'b0, y_q}) + SPD;
        y_d  = (!en_i || up_i == dn_i) ? y_q :
               up_i ? (y_up < 11'sd0 ? '0 : y_up[9:0]) :
               (y_dn > MAX ? MAX[9:0] : y_dn[9:0]);
    end

    always_ff @(posedge pixel_clk_i or negedge reset_n_i)
        if (!reset_n_i) y_q <= MID;
        else            y_q <= y_d;

    assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate game sequencer owning ball, paddles, scores and the
// serve/play/point/game-over flow; all outputs are registered.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_L_X   = DEF_PADDLE_L_X,
    parameter int PADDLE_R_X   = DEF_PADDLE_R_X,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic       pixel_clk_i,
    input  logic       reset_n_i,
    input  logic       frame_tick_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       l_up_i,
    input  logic       l_dn_i,
    input  logic       r_up_i,
    input  logic       r_dn_i,
    output coord_t     ball_x_o,
    output coord_t     ball_y_o,
    output coord_t     paddle_l_y_o,
    output coord_t     paddle_r_y_o,
    output logic [3:0] score_one_o,
    output logic [3:0] score_two_o,
    output logic [2:0] state_o,
    output logic [1:0] winner_o,
    output logic       point_pulse_o
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic signed [10:0] HR     = 11'(H_RES);
    localparam logic signed [10:0] VR     = 11'(V_RES);
    localparam logic signed [10:0] BSZ    = 11'(BALL_SIZE);
    localparam logic signed [10:0] PH     = 11'(PADDLE_H);
    localparam logic signed [10:0] SPD    = 11'(BALL_SPEED);
    localparam logic signed [10:0] L_EDGE = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [10:0] R_EDGE = 11'(PADDLE_R_X);
    localparam coord_t CX = coord_t'((H_RES - BALL_SIZE) / 2);
    localparam coord_t CY = coord_t'((V_RES - BALL_SIZE) / 2);

    state_e state_q, state_d;
    coord_t ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d, scorer_q, scorer_d, point_q, point_d;
    logic [3:0] score_one_q, score_one_d, score_two_q, score_two_d;
    logic [1:0] winner_q, winner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [10:0] bx, by, pl, pr, nx, ny;
    logic hit_l, hit_r, miss_l, miss_r, y_top, y_bot, win;
    logic new_game, move, pad_en, enter_serve;
    coord_t pad_l_y, pad_r_y;

    pong_paddle #(.V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)) u_pad_l (
        .pixel_clk_i(pixel_clk_i), .reset_n_i(reset_n_i), .en_i(pad_en),
        .up_i(l_up_i), .dn_i(l_dn_i), .y_o(pad_l_y)
    );
    pong_paddle #(.V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)) u_pad_r (
        .pixel_clk_i(pixel_clk_i), .reset_n_i(reset_n_i), .en_i(pad_en),
        .up_i(r_up_i), .dn_i(r_dn_i), .y_o(pad_r_y)
    );

    // Collision geometry against pre-update paddle rows; paddle hits outrank misses.
    always_comb begin
        bx     = $signed({1'b0, ball_x_q});
        by     = $signed({1'b0, ball_y_q});
        pl     = $signed({1'b0, pad_l_y});
        pr     = $signed({1'b0, pad_r_y});
        hit_l  = dx_neg_q && bx >= L_EDGE && bx - SPD <= L_EDGE && overlap(by, pl, BSZ, PH);
        hit_r  = !dx_neg_q && bx + BSZ <= R_EDGE && bx + BSZ + SPD >= R_EDGE && overlap(by, pr, BSZ, PH);
        miss_l = dx_neg_q && bx < SPD;
        miss_r = !dx_neg_q && bx + BSZ + SPD > HR;
        y_top  = dy_neg_q && by < SPD;
        y_bot  = !dy_neg_q && by + BSZ + SPD > VR;
        nx     = hit_l ? L_EDGE : hit_r ? R_EDGE - BSZ : dx_neg_q ? bx - SPD : bx + SPD;
        ny     = y_top ? '0 : y_bot ? VR - BSZ : dy_neg_q ? by - SPD : by + SPD;
        win    = scorer_q ? score_two_q == 4'(WIN_SCORE - 1) : score_one_q == 4'(WIN_SCORE - 1);
    end

    always_ff @(posedge pixel_clk_i or negedge reset_n_i)
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start_i) state_d = SERVE;
            SERVE:     if (frame_tick_i && cnt_q == CNT_W'(SERVE_FRAMES - 1)) state_d = PLAY;
            PLAY:      if (frame_tick_i && !pause_i && !hit_l && !hit_r && (miss_l || miss_r)) state_d = POINT;
            POINT:     state_d = win ? GAME_OVER : SERVE;
            GAME_OVER: if (start_i) state_d = SERVE;
            default:   state_d = IDLE;
        endcase
    end

    // A tick that changes state only changes state: motion needs state_d == state_q.
    always_comb begin
        new_game    = start_i && (state_q == IDLE || state_q == GAME_OVER);
        move        = frame_tick_i && !pause_i && state_q == PLAY && state_d == PLAY;
        pad_en      = move || (frame_tick_i && state_q == SERVE && state_d == SERVE);
        enter_serve = state_d == SERVE && state_q != SERVE;
        cnt_d       = (state_q == SERVE && state_d == SERVE) ? cnt_q + CNT_W'(frame_tick_i) : '0;
        ball_x_d    = state_d == SERVE ? CX : move ? coord_t'(nx) : ball_x_q;
        ball_y_d    = state_d == SERVE ? CY : move ? coord_t'(ny) : ball_y_q;
        dx_neg_d    = enter_serve ? (state_q == POINT && scorer_q) :
                      move ? (hit_l ? 1'b0 : hit_r ? 1'b1 : dx_neg_q) : dx_neg_q;
        dy_neg_d    = enter_serve ? 1'b0 : move ? (y_top ? 1'b0 : y_bot ? 1'b1 : dy_neg_q) : dy_neg_q;
        scorer_d    = (state_q == PLAY && state_d == POINT) ? miss_l : scorer_q;
        score_one_d = new_game ? '0 : score_one_q + 4'(state_q == POINT && !scorer_q);
        score_two_d = new_game ? '0 : score_two_q + 4'(state_q == POINT && scorer_q);
        winner_d    = new_game ? '0 : (state_q == POINT && win) ? (scorer_q ? 2'b10 : 2'b01) : winner_q;
        point_d     = state_q == POINT;
    end

    always_ff @(posedge pixel_clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            ball_x_q    <= CX;
            ball_y_q    <= CY;
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            scorer_q    <= 1'b0;
            point_q     <= 1'b0;
            score_one_q <= '0;
            score_two_q <= '0;
            winner_q    <= '0;
            cnt_q       <= '0;
        end else begin
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            scorer_q    <= scorer_d;
            point_q     <= point_d;
            score_one_q <= score_one_d;
            score_two_q <= score_two_d;
            winner_q    <= winner_d;
            cnt_q       <= cnt_d;
        end

    assign ball_x_o      = ball_x_q;
    assign ball_y_o      = ball_y_q;
    assign paddle_l_y_o  = pad_l_y;
    assign paddle_r_y_o  = pad_r_y;
    assign score_one_o   = score_one_q;
    assign score_two_o   = score_two_q;
    assign state_o       = state_q;
    assign winner_o      = winner_q;
    assign point_pulse_o = point_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed frame-by-frame stimulus with hand-computed ball,
// paddle, score and state expectations.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic clk = 0, rst_n = 0, tick = 0, start = 0, pause = 0;
    logic l_up = 0, l_dn = 0, r_up = 0, r_dn = 0;
    coord_t bx, by, pl, pr;
    logic [3:0] s1, s2;
    logic [2:0] st;
    logic [1:0] win;
    logic pp;
    int checks = 0, errors = 0, n;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .pixel_clk_i(clk), .reset_n_i(rst_n), .frame_tick_i(tick), .start_i(start), .pause_i(pause),
        .l_up_i(l_up), .l_dn_i(l_dn), .r_up_i(r_up), .r_dn_i(r_dn),
        .ball_x_o(bx), .ball_y_o(by), .paddle_l_y_o(pl), .paddle_r_y_o(pr),
        .score_one_o(s1), .score_two_o(s2), .state_o(st), .winner_o(win), .point_pulse_o(pp)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ticks(input int cnt);
        repeat (cnt) begin
            @(negedge clk) tick = 1;
            @(negedge clk) tick = 0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_point(output int cnt);
        cnt = 0;
        while (st != POINT && cnt < 300) begin
            ticks(1);
            cnt++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", st, IDLE);
        check("rst_bx", bx, 307);
        check("rst_by", by, 227);
        check("rst_pl", pl, 165);
        check("rst_pr", pr, 165);
        check("rst_scores", {s1, s2}, 0);
        check("rst_winner", win, 0);
        check("rst_pulse", pp, 0);
        rst_n = 1;

        pulse_start();
        check("start_serve", st, SERVE);
        l_up = 1; r_dn = 1;
        ticks(40);
        check("pl_sat_top", pl, 0);
        check("pr_sat_bot", pr, 330);
        check("serve_40", st, SERVE);
        l_dn = 1; r_up = 1;
        ticks(5);
        check("pl_both_hold", pl, 0);
        check("pr_both_hold", pr, 330);
        l_up = 0; l_dn = 0; r_up = 0; r_dn = 0;
        ticks(14);
        check("serve_59", st, SERVE);
        ticks(1);
        check("play_60", st, PLAY);
        check("play_bx0", bx, 307);
        check("play_by0", by, 227);
        ticks(1);
        check("move_bx1", bx, 311);
        check("move_by1", by, 231);
        pulse_start();
        check("start_ign", st, PLAY);

        pause = 1; l_dn = 1;
        ticks(10);
        check("pause_bx", bx, 311);
        check("pause_by", by, 231);
        check("pause_pl", pl, 0);
        pause = 0; l_dn = 0;

        ticks(56);
        check("k57_bx", bx, 535);
        check("k57_by", by, 455);
        ticks(1);
        check("bounce_by", by, 455);
        ticks(1);
        check("after_bounce_by", by, 451);
        ticks(7);
        check("k66_bx", bx, 571);
        check("k66_by", by, 423);
        ticks(1);
        check("hit_r_bx", bx, 575);
        check("hit_r_by", by, 419);
        check("hit_r_state", st, PLAY);
        check("hit_r_s1", s1, 0);
        ticks(1);
        check("ret_bx", bx, 571);
        check("ret_by", by, 415);

        l_dn = 1;
        wait_point(n);
        check("p2_point_state", st, POINT);
        @(negedge clk);
        check("p2_s2", s2, 1);
        check("p2_s1", s1, 0);
        check("p2_pulse", pp, 1);
        check("p2_serve", st, SERVE);
        check("p2_centre_x", bx, 307);
        @(negedge clk);
        check("p2_pulse_end", pp, 0);
        l_dn = 0;

        ticks(62);
        check("b_play", st, PLAY);
        @(negedge clk) rst_n = 0;
        #1;
        check("mid_rst_state", st, IDLE);
        check("mid_rst_bx", bx, 307);
        check("mid_rst_by", by, 227);
        check("mid_rst_pl", pl, 165);
        check("mid_rst_pr", pr, 165);
        check("mid_rst_s2", s2, 0);
        @(negedge clk) rst_n = 1;

        pulse_start();
        r_up = 1;
        for (int i = 1; i <= 9; i++) begin
            ticks(60);
            wait_point(n);
            if (i == 1) check("p1_miss_ticks", n, 78);
            check("p1_point_state", st, POINT);
            @(negedge clk);
            check("p1_score", s1, i);
        end
        r_up = 0;
        check("go_state", st, GAME_OVER);
        check("go_winner", win, 1);
        check("go_s2", s2, 0);
        ticks(3);
        check("go_frozen_bx", bx, 615);
        check("go_hold", st, GAME_OVER);
        pulse_start();
        check("restart_state", st, SERVE);
        check("restart_s1", s1, 0);
        check("restart_winner", win, 0);
        check("restart_bx", bx, 307);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
